// File: rtl/alarm_timekeeper_pkg.sv
// Shared types and constants for the alarm timekeeper: FSM state encoding,
// field moduli and the hour modulus derived from the 12/24-hour mode.
package alarm_timekeeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_t;

    localparam int SEC_MAX = 60;
    localparam int MIN_MAX = 60;

    function automatic int hmax(input int hours_24);
        return (hours_24 != 0) ? 24 : 12;
    endfunction

endpackage

// File: rtl/alarm_timekeeper_mod_counter.sv
// Modulo-MODULUS up counter; carry flags the increment that wraps to zero.
module mod_counter #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic             carry,
    output logic [WIDTH-1:0] value
);

    assign carry = inc && (value == WIDTH'(MODULUS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc) begin
            value <= carry ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day clock with N_ALARMS alarm channels and an IDLE/RING/SNOOZE
// ringer. Handshake-free: every control input is a one-cycle pulse on clk.
module alarm_timekeeper
    import alarm_timekeeper_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int HOURS_24   = 0,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_1hz,
    input  logic                adj_sec,
    input  logic                adj_min,
    input  logic                adj_hour,
    input  logic [AW-1:0]       al_sel,
    input  logic                al_adj_min,
    input  logic                al_adj_hour,
    input  logic                al_toggle,
    input  logic                snooze,
    input  logic                dismiss,
    output logic [5:0]          seconds,
    output logic [5:0]          minutes,
    output logic [4:0]          hours,
    output logic [5:0]          al_minutes,
    output logic [4:0]          al_hours,
    output logic [N_ALARMS-1:0] al_enable,
    output logic                ringing,
    output logic                snoozing,
    output logic [AW-1:0]       ring_idx,
    output alarm_state_t        fsm_state
);

    localparam int HMAX         = hmax(HOURS_24);
    localparam int SNOOZE_TICKS = SNOOZE_MIN * SEC_MAX;
    localparam int SW           = $clog2(SNOOZE_TICKS + 1);

    // An adjust pulse landing on a tick is parked and applied on the next
    // non-tick cycle; a fresh pulse arriving while one is parked waits its turn.
    logic pend_sec, pend_min, pend_hour;
    logic req_sec, req_min, req_hour;
    logic do_sec, do_min, do_hour;

    assign req_sec  = adj_sec  | pend_sec;
    assign req_min  = adj_min  | pend_min;
    assign req_hour = adj_hour | pend_hour;
    assign do_sec   = req_sec  & ~tick_1hz;
    assign do_min   = req_min  & ~tick_1hz;
    assign do_hour  = req_hour & ~tick_1hz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_sec  <= 1'b0;
            pend_min  <= 1'b0;
            pend_hour <= 1'b0;
        end else begin
            pend_sec  <= tick_1hz ? req_sec  : (adj_sec  & pend_sec);
            pend_min  <= tick_1hz ? req_min  : (adj_min  & pend_min);
            pend_hour <= tick_1hz ? req_hour : (adj_hour & pend_hour);
        end
    end

    // Carries only ripple on a real tick, so adjusts never spill into the next field.
    logic sec_carry, min_carry, hour_carry_unused;

    mod_counter #(.WIDTH(6), .MODULUS(SEC_MAX)) u_sec (
        .clk(clk), .reset_n(reset_n), .inc(tick_1hz | do_sec),
        .carry(sec_carry), .value(seconds)
    );
    mod_counter #(.WIDTH(6), .MODULUS(MIN_MAX)) u_min (
        .clk(clk), .reset_n(reset_n), .inc((sec_carry & tick_1hz) | do_min),
        .carry(min_carry), .value(minutes)
    );
    mod_counter #(.WIDTH(5), .MODULUS(HMAX)) u_hour (
        .clk(clk), .reset_n(reset_n), .inc((min_carry & tick_1hz) | do_hour),
        .carry(hour_carry_unused), .value(hours)
    );

    logic [5:0]          al_min_v [N_ALARMS];
    logic [4:0]          al_hr_v  [N_ALARMS];
    logic [N_ALARMS-1:0] al_min_carry_unused, al_hr_carry_unused, sel_hit;

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_al
        assign sel_hit[i] = (al_sel == AW'(i));
        mod_counter #(.WIDTH(6), .MODULUS(MIN_MAX)) u_al_min (
            .clk(clk), .reset_n(reset_n), .inc(al_adj_min & sel_hit[i]),
            .carry(al_min_carry_unused[i]), .value(al_min_v[i])
        );
        mod_counter #(.WIDTH(5), .MODULUS(HMAX)) u_al_hr (
            .clk(clk), .reset_n(reset_n), .inc(al_adj_hour & sel_hit[i]),
            .carry(al_hr_carry_unused[i]), .value(al_hr_v[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_enable <= '0;
        end else if (al_toggle) begin
            al_enable <= al_enable ^ sel_hit;
        end
    end

    logic [5:0] sel_min;
    logic [4:0] sel_hr;

    always_comb begin
        sel_min = '0;
        sel_hr  = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (sel_hit[i]) begin
                sel_min = al_min_v[i];
                sel_hr  = al_hr_v[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_minutes <= '0;
            al_hours   <= '0;
        end else begin
            al_minutes <= sel_min;
            al_hours   <= sel_hr;
        end
    end

    // Match against the time the wrapping tick is about to produce.
    logic [5:0]    next_min;
    logic [4:0]    next_hour;
    logic          hit, trigger, ring_ch_en, kill;
    logic [AW-1:0] hit_idx;

    assign next_min  = (minutes == 6'(MIN_MAX - 1)) ? '0 : minutes + 6'd1;
    assign next_hour = (minutes != 6'(MIN_MAX - 1)) ? hours :
                       (hours == 5'(HMAX - 1)) ? '0 : hours + 5'd1;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        ring_ch_en = 1'b0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (al_enable[i] && al_min_v[i] == next_min && al_hr_v[i] == next_hour) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
            if (ring_idx == AW'(i)) begin
                ring_ch_en = al_enable[i];
            end
        end
    end

    assign trigger = hit & sec_carry & tick_1hz;
    assign kill    = al_toggle && (al_sel == ring_idx) && ring_ch_en;

    alarm_state_t   state;
    logic [7:0]     ring_cnt;
    logic [SW-1:0]  snooze_cnt;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            ring_idx   <= '0;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state    <= ST_RING;
                        ringing  <= 1'b1;
                        ring_idx <= hit_idx;
                        ring_cnt <= '0;
                    end
                end
                ST_RING: begin
                    if (dismiss || kill) begin
                        state   <= ST_IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state      <= ST_SNOOZE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                        snooze_cnt <= SW'(SNOOZE_TICKS);
                    end else if (tick_1hz) begin
                        if (ring_cnt == 8'(RING_SEC - 1)) begin
                            state   <= ST_IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss || kill) begin
                        state    <= ST_IDLE;
                        snoozing <= 1'b0;
                    end else if (tick_1hz) begin
                        if (snooze_cnt == SW'(1)) begin
                            state    <= ST_RING;
                            snoozing <= 1'b0;
                            ringing  <= 1'b1;
                            ring_cnt <= '0;
                        end else begin
                            snooze_cnt <= snooze_cnt - SW'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench for alarm_timekeeper: a 12-hour instance checked against a seconds-count
// reference model, plus a 24-hour instance sharing its inputs for hour wrap.
module tb_alarm_timekeeper;
    import alarm_timekeeper_pkg::*;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int RS = 5;
    localparam int SM = 1;

    localparam int OP_TICK = 0, OP_SEC = 1, OP_MIN = 2, OP_HOUR = 3, OP_AMIN = 4,
                   OP_AHOUR = 5, OP_TOG = 6, OP_SNZ = 7, OP_DIS = 8;

    logic clk = 1'b0, reset_n = 1'b0;
    logic tick_1hz = 1'b0, adj_sec = 1'b0, adj_min = 1'b0, adj_hour = 1'b0;
    logic al_adj_min = 1'b0, al_adj_hour = 1'b0, al_toggle = 1'b0;
    logic snooze = 1'b0, dismiss = 1'b0;
    logic [AW-1:0] al_sel = '0;

    logic [5:0] seconds, minutes, al_minutes, seconds24, minutes24, al_minutes24;
    logic [4:0] hours, al_hours, hours24, al_hours24;
    logic [N-1:0] al_enable, al_enable24;
    logic ringing, snoozing, ringing24, snoozing24;
    logic [AW-1:0] ring_idx, ring_idx24;
    alarm_state_t state_dbg, state_dbg24;

    alarm_timekeeper #(.N_ALARMS(N), .HOURS_24(0), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .adj_sec(adj_sec),
        .adj_min(adj_min), .adj_hour(adj_hour), .al_sel(al_sel), .al_adj_min(al_adj_min),
        .al_adj_hour(al_adj_hour), .al_toggle(al_toggle), .snooze(snooze), .dismiss(dismiss),
        .seconds(seconds), .minutes(minutes), .hours(hours), .al_minutes(al_minutes),
        .al_hours(al_hours), .al_enable(al_enable), .ringing(ringing), .snoozing(snoozing),
        .ring_idx(ring_idx), .fsm_state(state_dbg)
    );

    alarm_timekeeper #(.N_ALARMS(N), .HOURS_24(1), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut24 (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .adj_sec(adj_sec),
        .adj_min(adj_min), .adj_hour(adj_hour), .al_sel(al_sel), .al_adj_min(al_adj_min),
        .al_adj_hour(al_adj_hour), .al_toggle(al_toggle), .snooze(snooze), .dismiss(dismiss),
        .seconds(seconds24), .minutes(minutes24), .hours(hours24), .al_minutes(al_minutes24),
        .al_hours(al_hours24), .al_enable(al_enable24), .ringing(ringing24),
        .snoozing(snoozing24), .ring_idx(ring_idx24), .fsm_state(state_dbg24)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // reference model: time as seconds since midnight; ringer as plain counters
    int t12, t24;
    int am[N], ah[N];
    bit ae[N];
    int st;           // 0 idle, 1 ring, 2 snooze
    int idx, ring_left, snooze_left;

    function automatic int bump(input int t, input int f, input int h);
        int s, m, hr;
        s  = t % 60;
        m  = (t / 60) % 60;
        hr = t / 3600;
        case (f)
            0:       s  = (s + 1) % 60;
            1:       m  = (m + 1) % 60;
            default: hr = (hr + 1) % h;
        endcase
        return hr * 3600 + m * 60 + s;
    endfunction

    task automatic m_reset();
        t12 = 0; t24 = 0; st = 0; idx = 0; ring_left = 0; snooze_left = 0;
        for (int i = 0; i < N; i++) begin
            am[i] = 0; ah[i] = 0; ae[i] = 1'b0;
        end
    endtask

    task automatic m_tick();
        bit wrap;
        wrap = (t12 % 60) == 59;
        t12 = (t12 + 1) % (12 * 3600);
        t24 = (t24 + 1) % (24 * 3600);
        if (st == 0) begin
            if (wrap) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (ae[i] && ah[i] == t12 / 3600 && am[i] == (t12 / 60) % 60) begin
                        st = 1; idx = i; ring_left = RS;
                    end
                end
            end
        end else if (st == 1) begin
            ring_left--;
            if (ring_left == 0) st = 0;
        end else begin
            snooze_left--;
            if (snooze_left == 0) begin
                st = 1; ring_left = RS;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        logic [N-1:0] en_exp;
        for (int i = 0; i < N; i++) en_exp[i] = ae[i];
        chk({tag, ".sec"},   seconds, t12 % 60);
        chk({tag, ".min"},   minutes, (t12 / 60) % 60);
        chk({tag, ".hour"},  hours,   t12 / 3600);
        chk({tag, ".sec24"}, seconds24, t24 % 60);
        chk({tag, ".min24"}, minutes24, (t24 / 60) % 60);
        chk({tag, ".hr24"},  hours24, t24 / 3600);
        chk({tag, ".ring"},  ringing,  st == 1);
        chk({tag, ".snz"},   snoozing, st == 2);
        chk({tag, ".idx"},   ring_idx, idx);
        chk({tag, ".en"},    al_enable, en_exp);
        chk({tag, ".almin"}, al_minutes, am[al_sel]);
        chk({tag, ".alhr"},  al_hours,   ah[al_sel]);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        check_now(tag);
    endtask

    // driver: one pulse per call, model updated after the pulse is consumed
    task automatic do_op(input int op, input int sel);
        @(negedge clk);
        if (op == OP_AMIN || op == OP_AHOUR || op == OP_TOG) al_sel = AW'(sel);
        case (op)
            OP_TICK:  tick_1hz    = 1'b1;
            OP_SEC:   adj_sec     = 1'b1;
            OP_MIN:   adj_min     = 1'b1;
            OP_HOUR:  adj_hour    = 1'b1;
            OP_AMIN:  al_adj_min  = 1'b1;
            OP_AHOUR: al_adj_hour = 1'b1;
            OP_TOG:   al_toggle   = 1'b1;
            OP_SNZ:   snooze      = 1'b1;
            default:  dismiss     = 1'b1;
        endcase
        @(negedge clk);
        tick_1hz = 1'b0; adj_sec = 1'b0; adj_min = 1'b0; adj_hour = 1'b0;
        al_adj_min = 1'b0; al_adj_hour = 1'b0; al_toggle = 1'b0;
        snooze = 1'b0; dismiss = 1'b0;
        case (op)
            OP_TICK:  m_tick();
            OP_SEC:   begin t12 = bump(t12, 0, 12); t24 = bump(t24, 0, 24); end
            OP_MIN:   begin t12 = bump(t12, 1, 12); t24 = bump(t24, 1, 24); end
            OP_HOUR:  begin t12 = bump(t12, 2, 12); t24 = bump(t24, 2, 24); end
            OP_AMIN:  am[sel] = (am[sel] + 1) % 60;
            OP_AHOUR: ah[sel] = (ah[sel] + 1) % 12;
            OP_TOG: begin
                ae[sel] = !ae[sel];
                if (st != 0 && sel == idx && !ae[sel]) st = 0;
            end
            OP_SNZ: if (st == 1) begin st = 2; snooze_left = SM * 60; end
            default: st = 0;
        endcase
    endtask

    task automatic repeat_op(input int op, input int sel, input int n);
        for (int i = 0; i < n; i++) do_op(op, sel);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        al_sel  = '0;
        m_reset();
        #2;
        check_now(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset("reset");

        // hour wrap in both modes: 23 hour pulses give 11 in 12h mode, 23 in 24h
        repeat_op(OP_HOUR, 0, 23);
        repeat_op(OP_MIN, 0, 59);
        repeat_op(OP_SEC, 0, 59);
        chk("wrap.pre_h12", hours, 11);
        chk("wrap.pre_h24", hours24, 23);
        check_now("wrap.pre");
        do_op(OP_TICK, 0);
        chk("wrap.h12", {hours, minutes, seconds}, 0);
        chk("wrap.h24", {hours24, minutes24, seconds24}, 0);
        check_now("wrap.post");

        // randomized mixed operations against the model
        for (int k = 0; k < 150; k++) begin
            int r, op;
            r  = $urandom_range(0, 11);
            op = (r > 8) ? OP_TICK : r;
            do_op(op, $urandom_range(0, N - 1));
            check_all($sformatf("rnd%0d", k));
        end

        // adjust coincident with tick is deferred one cycle
        do_reset("reset2");
        repeat_op(OP_HOUR, 0, 10);
        repeat_op(OP_MIN, 0, 15);
        repeat_op(OP_SEC, 0, 30);
        @(negedge clk);
        adj_min = 1'b1; tick_1hz = 1'b1;
        @(negedge clk);
        adj_min = 1'b0; tick_1hz = 1'b0;
        m_tick();
        chk("coinc.c1_min", minutes, 15);
        chk("coinc.c1_sec", seconds, 31);
        check_now("coinc.c1");
        t12 = bump(t12, 1, 12); t24 = bump(t24, 1, 24);
        @(negedge clk);
        chk("coinc.c2_min", minutes, 16);
        chk("coinc.c2_hr", hours, 10);
        check_now("coinc.c2");

        // two channels on 07:30, lowest index wins
        do_reset("reset3");
        for (int ch = 1; ch <= 2; ch++) begin
            repeat_op(OP_AHOUR, ch, 7);
            repeat_op(OP_AMIN, ch, 30);
            do_op(OP_TOG, ch);
        end
        repeat_op(OP_HOUR, 0, 7);
        repeat_op(OP_MIN, 0, 29);
        repeat_op(OP_SEC, 0, 59);
        check_all("trig.pre");
        do_op(OP_TICK, 0);
        chk("trig.ringing", ringing, 1);
        chk("trig.idx", ring_idx, 1);
        check_now("trig.post");

        // snooze for one minute, ring again, then auto-silence
        do_op(OP_SNZ, 0);
        chk("snz.snoozing", snoozing, 1);
        chk("snz.ringing", ringing, 0);
        for (int i = 0; i < 59; i++) begin
            do_op(OP_TICK, 0);
            check_now($sformatf("snz.t%0d", i));
        end
        do_op(OP_TICK, 0);
        chk("snz.rering", ringing, 1);
        chk("snz.off", snoozing, 0);
        repeat_op(OP_TICK, 0, RS - 1);
        chk("snz.still", ringing, 1);
        do_op(OP_TICK, 0);
        chk("snz.timeout", ringing, 0);
        check_now("snz.idle");

        // adjusting onto an alarm never rings; disabling the ringing channel stops it
        do_reset("reset4");
        do_op(OP_AMIN, 0);
        do_op(OP_TOG, 0);
        do_op(OP_MIN, 0);
        check_all("adj.noring");
        chk("adj.ringing", ringing, 0);
        do_op(OP_AMIN, 0);
        repeat_op(OP_SEC, 0, 59);
        do_op(OP_TICK, 0);
        chk("tog.ring", ringing, 1);
        chk("tog.idx", ring_idx, 0);
        do_op(OP_TOG, 0);
        chk("tog.ringing", ringing, 0);
        chk("tog.en", al_enable, 0);
        check_all("tog.post");

        // dismiss beats snooze in the same cycle
        do_op(OP_TOG, 0);
        do_op(OP_AMIN, 0);
        repeat_op(OP_SEC, 0, 59);
        do_op(OP_TICK, 0);
        chk("prio.ring", ringing, 1);
        @(negedge clk);
        snooze = 1'b1; dismiss = 1'b1;
        @(negedge clk);
        snooze = 1'b0; dismiss = 1'b0;
        st = 0;
        chk("prio.ringing", ringing, 0);
        chk("prio.snoozing", snoozing, 0);
        check_now("prio.post");

        // asynchronous reset while snoozing
        do_op(OP_AMIN, 0);
        repeat_op(OP_SEC, 0, 59);
        do_op(OP_TICK, 0);
        do_op(OP_SNZ, 0);
        chk("ares.pre_snz", snoozing, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ares.ringing", ringing, 0);
        chk("ares.snoozing", snoozing, 0);
        chk("ares.idx", ring_idx, 0);
        chk("ares.en", al_enable, 0);
        chk("ares.time", {hours, minutes, seconds}, 0);
        chk("ares.alarm", {al_hours, al_minutes}, 0);
        m_reset();
        al_sel = '0;
        check_now("ares.all");
        @(negedge clk);
        reset_n = 1'b1;
        check_all("ares.released");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_timekeeper.md
ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4: number of independent alarm channels (1..8).
REQ-002 SHALL have parameter HOURS_24, default 0: 0 = hours 0..11, 1 = hours 0..23.
REQ-003 SHALL have parameter SNOOZE_MIN, default 5: snooze duration in minutes (1..30).
REQ-004 SHALL have parameter RING_SEC, default 60: auto-silence timeout in seconds (1..255).
REQ-005 SHALL use one clock and an asynchronous active-low reset; all other inputs are synchronous to clk.
REQ-006 SHALL have ports:
- clk  in  1  system clock (31.5 MHz)
- reset_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- adj_sec / adj_min / adj_hour  in  1 each  debounced one-cycle adjust pulses
- al_sel  in  AW  selected alarm index, AW = max(1, clog2(N_ALARMS))
- al_adj_min / al_adj_hour  in  1 each  adjust pulses for the selected alarm
- al_toggle  in  1  pulse; toggles the selected alarm's enable
- snooze / dismiss  in  1 each  user pulses
- seconds, minutes  out  6 each  current time
- hours  out  5  current hour
- al_minutes, al_hours  out  6, 5  time of the selected alarm
- al_enable  out  N_ALARMS  per-channel enable
- ringing  out  1  buzzer gate, high in RING only
- snoozing  out  1  high in SNOOZE
- ring_idx  out  AW  channel that triggered the current RING/SNOOZE

Function
REQ-007 On tick_1hz, time SHALL advance one second with full carry in the same cycle: 59 s -> 0 with minutes+1; 59:59 -> hours+1; last hour (11 or 23) wraps to 0.
REQ-008 Adjust pulses SHALL increment only their own field, modulo 60 or HMAX, with no carry (adj_min at 59 -> 0, hours unchanged).
REQ-009 An adjust pulse coincident with tick_1hz SHALL be held in a per-field pending flag and applied on the next cycle; no pulse is lost.
REQ-010 al_adj_min / al_adj_hour SHALL increment the al_sel channel only, modulo 60 / HMAX, with no carry.
REQ-011 Alarm fields SHALL never exceed their range; time fields SHALL never exceed their range.
REQ-012 A match SHALL be evaluated only on a tick that wraps seconds to 0: the new hours:minutes equal an enabled channel's time -> trigger; lowest matching index wins.
REQ-013 Adjust-induced time changes SHALL never trigger an alarm.
REQ-014 FSM states: IDLE, RING, SNOOZE.
- IDLE -> RING on trigger; ring_idx latched and ring second-counter cleared.
- RING -> IDLE after RING_SEC ticks, on dismiss, or on al_toggle disabling ring_idx.
- RING -> SNOOZE on snooze; counter loaded with SNOOZE_MIN*60.
- SNOOZE -> RING when the counter reaches 0 on a tick; ring counter reloaded.
- SNOOZE -> IDLE on dismiss or on disabling ring_idx.
REQ-015 Triggers occurring in RING or SNOOZE SHALL be ignored.
REQ-016 Same-cycle priority SHALL be: dismiss > snooze > timeout/expiry.
REQ-017 Outputs SHALL be registered; ringing rises one cycle after the triggering tick.

Reset
REQ-018 While reset_n is low:
- time SHALL be 00:00:00;
- all alarms SHALL be 00:00 and disabled;
- state SHALL be IDLE;
- ringing, snoozing, ring_idx and pending flags SHALL be 0.
REQ-019 Reset asserted mid-RING SHALL drop ringing asynchronously, without waiting for clk.

Structure
REQ-020 Package alarm_timekeeper_pkg SHALL hold the FSM state enum, SEC_MAX=60, MIN_MAX=60, and HMAX as a function of HOURS_24.
REQ-021 Modulo-increment logic SHALL be one sub-module, mod_counter (parameters WIDTH, MODULUS; ports inc, carry, value), reused for time and alarm fields.

Verification
REQ-022 Scenario: set 11:59:59 with HOURS_24=0, then tick -> 00:00:00 in one cycle; with HOURS_24=1, 23:59:59 -> 00:00:00.
REQ-023 Scenario: adj_min and tick_1hz in the same cycle at 10:15:30 -> 10:15:31 the first cycle, 10:16:31 the next.
REQ-024 Scenario: alarms 1 and 2 both enabled at 07:30, time 07:29:59, tick -> ringing=1 one cycle later, ring_idx=1.
REQ-025 Scenario: ringing, snooze with SNOOZE_MIN=1 -> snoozing=1; 60 ticks later -> ringing=1; RING_SEC ticks later -> IDLE.
REQ-026 Scenario: adj_min moves time onto an enabled alarm -> ringing stays 0; in RING, al_toggle with al_sel=ring_idx -> IDLE and al_enable bit cleared.
REQ-027 Scenario: reset_n low mid-SNOOZE -> all outputs 0 and alarms disabled, asynchronously.
